// File: rtl/lcd_write_sequencer_if.sv
// Handshake and pin bundle between the character/command controller,
// the LCD write sequencer and the HD44780 4-bit bus.
interface lcd_write_sequencer_if;
    logic       start;
    logic [7:0] data_in;
    logic       rs_in;
    logic       long_wait;
    logic       single_nibble;
    logic       ready;
    logic       done;
    logic       overrun;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_db;

    // Controller side: issues write requests and watches the pins
    modport master (
        output start, data_in, rs_in, long_wait, single_nibble,
        input  ready, done, overrun, lcd_e, lcd_rs, lcd_rw, lcd_db
    );

    // Sequencer side: consumes requests and drives the LCD pins
    modport slave (
        input  start, data_in, rs_in, long_wait, single_nibble,
        output ready, done, overrun, lcd_e, lcd_rs, lcd_rw, lcd_db
    );
endinterface

// File: rtl/lcd_write_sequencer.sv
// HD44780 4-bit write-timing engine: one byte per start handshake, split into
// upper/lower nibbles with programmable setup, enable pulse, gap and post-write wait.
module lcd_write_sequencer #(
    parameter int E_SETUP_CYC    = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int GAP_CYC        = 50,
    parameter int SHORT_WAIT_CYC = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int CNT_W          = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    lcd_write_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(E_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] wait_last;
    logic             accept;

    logic [7:0] data_q, data_n;
    logic       rs_q, rs_n;
    logic       long_q, long_n;
    logic       single_q, single_n;

    logic       ready_q, ready_n;
    logic       done_q, done_n;
    logic       overrun_q, overrun_n;
    logic       e_q, e_n;
    logic       lcd_rs_q, lcd_rs_n;
    logic [3:0] db_q, db_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            data_q    <= '0;
            rs_q      <= 1'b0;
            long_q    <= 1'b0;
            single_q  <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            e_q       <= 1'b0;
            lcd_rs_q  <= 1'b0;
            db_q      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            data_q    <= data_n;
            rs_q      <= rs_n;
            long_q    <= long_n;
            single_q  <= single_n;
            ready_q   <= ready_n;
            done_q    <= done_n;
            overrun_q <= overrun_n;
            e_q       <= e_n;
            lcd_rs_q  <= lcd_rs_n;
            db_q      <= db_n;
        end
    end

    // Pin values are derived from the next state so they are registered yet
    // line up exactly with the state they belong to.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        wait_last = long_q ? LONG_LAST : SHORT_LAST;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_n = ST_SETUP_HI;
                end
            end
            ST_SETUP_HI: if (cnt == SETUP_LAST) state_n = ST_PULSE_HI;
            ST_PULSE_HI: if (cnt == PULSE_LAST) state_n = single_q ? ST_WAIT : ST_GAP;
            ST_GAP:      if (cnt == GAP_LAST)   state_n = ST_SETUP_LO;
            ST_SETUP_LO: if (cnt == SETUP_LAST) state_n = ST_PULSE_LO;
            ST_PULSE_LO: if (cnt == PULSE_LAST) state_n = ST_WAIT;
            ST_WAIT:     if (cnt == wait_last)  state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase

        if (state_n != state || state == ST_IDLE) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt + CNT_W'(1);
        end

        data_n   = accept ? bus.data_in       : data_q;
        rs_n     = accept ? bus.rs_in         : rs_q;
        long_n   = accept ? bus.long_wait     : long_q;
        single_n = accept ? bus.single_nibble : single_q;

        ready_n   = (state_n == ST_IDLE);
        done_n    = (state == ST_WAIT) && (state_n == ST_IDLE);
        overrun_n = bus.start && (state != ST_IDLE);
        e_n       = (state_n == ST_PULSE_HI) || (state_n == ST_PULSE_LO);

        // Bus lines hold through WAIT and IDLE so nothing moves as lcd_e falls
        db_n     = db_q;
        lcd_rs_n = lcd_rs_q;
        case (state_n)
            ST_SETUP_HI, ST_PULSE_HI, ST_GAP: db_n = data_n[7:4];
            ST_SETUP_LO, ST_PULSE_LO:         db_n = data_n[3:0];
            default:                          db_n = db_q;
        endcase
        if (state_n != ST_IDLE) begin
            lcd_rs_n = rs_n;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
    assign bus.lcd_e   = e_q;
    assign bus.lcd_rs  = lcd_rs_q;
    assign bus.lcd_rw  = 1'b0;
    assign bus.lcd_db  = db_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: directed writes, held start, mid-write reset
// and randomized traffic against a per-write timeline model.
module tb_lcd_write_sequencer;

    localparam int E_SETUP = 2;
    localparam int E_PULSE = 3;
    localparam int GAP     = 4;
    localparam int SHORT_W = 5;
    localparam int LONG_W  = 9;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lcd_write_sequencer_if bus();

    lcd_write_sequencer #(
        .E_SETUP_CYC    (E_SETUP),
        .E_PULSE_CYC    (E_PULSE),
        .GAP_CYC        (GAP),
        .SHORT_WAIT_CYC (SHORT_W),
        .LONG_WAIT_CYC  (LONG_W),
        .CNT_W          (17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       e;
        logic       rs;
        logic [3:0] db;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur_exp;
    exp_t       reset_exp;
    logic       exp_ov;
    int         checks = 0;
    int         passes = 0;
    int         busy_cnt, pulse_cnt, done_cnt, ov_cnt, writes_cnt;
    logic       prev_e;
    logic [3:0] prev_db;
    logic       prev_rs;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_count(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ready"},   8'(bus.ready),   8'h01);
        check_output({tag, "_done"},    8'(bus.done),    8'h00);
        check_output({tag, "_overrun"}, 8'(bus.overrun), 8'h00);
        check_output({tag, "_e"},       8'(bus.lcd_e),   8'h00);
        check_output({tag, "_rs"},      8'(bus.lcd_rs),  8'h00);
        check_output({tag, "_db"},      8'(bus.lcd_db),  8'h00);
        check_output({tag, "_rw"},      8'(bus.lcd_rw),  8'h00);
    endtask

    task automatic push_segment(input int n, input logic e, input logic r, input logic [3:0] db);
        exp_t x;
        x.ready = 1'b0;
        x.done  = 1'b0;
        x.e     = e;
        x.rs    = r;
        x.db    = db;
        for (int i = 0; i < n; i++) exp_q.push_back(x);
    endtask

    // Whole visible timeline of one write, ending with the done/idle cycle
    task automatic push_write(input logic [7:0] d, input logic r, input logic lw, input logic sn);
        logic [3:0] last;
        exp_t       fin;
        push_segment(E_SETUP, 1'b0, r, d[7:4]);
        push_segment(E_PULSE, 1'b1, r, d[7:4]);
        last = d[7:4];
        if (!sn) begin
            push_segment(GAP,     1'b0, r, d[7:4]);
            push_segment(E_SETUP, 1'b0, r, d[3:0]);
            push_segment(E_PULSE, 1'b1, r, d[3:0]);
            last = d[3:0];
        end
        push_segment(lw ? LONG_W : SHORT_W, 1'b0, r, last);
        fin.ready = 1'b1;
        fin.done  = 1'b1;
        fin.e     = 1'b0;
        fin.rs    = r;
        fin.db    = last;
        exp_q.push_back(fin);
        writes_cnt++;
    endtask

    task automatic apply_stimulus(input logic st, input logic [7:0] d, input logic r,
                                  input logic lw, input logic sn);
        bus.start         = st;
        bus.data_in       = d;
        bus.rs_in         = r;
        bus.long_wait     = lw;
        bus.single_nibble = sn;
        @(posedge clk);
        exp_ov = st && !cur_exp.ready;
        if (exp_q.size() == 0 && cur_exp.ready && st) push_write(d, r, lw, sn);
        if (exp_q.size() != 0) begin
            cur_exp = exp_q.pop_front();
        end else begin
            cur_exp.ready = 1'b1;
            cur_exp.done  = 1'b0;
            cur_exp.e     = 1'b0;
        end
        @(negedge clk);
        check_output("ready",   8'(bus.ready),   8'(cur_exp.ready));
        check_output("done",    8'(bus.done),    8'(cur_exp.done));
        check_output("overrun", 8'(bus.overrun), 8'(exp_ov));
        check_output("lcd_e",   8'(bus.lcd_e),   8'(cur_exp.e));
        check_output("lcd_rs",  8'(bus.lcd_rs),  8'(cur_exp.rs));
        check_output("lcd_db",  8'(bus.lcd_db),  8'(cur_exp.db));
        check_output("lcd_rw",  8'(bus.lcd_rw),  8'h00);
        if (prev_e === 1'b1) begin
            check_output("hold_db", 8'(bus.lcd_db), 8'(prev_db));
            check_output("hold_rs", 8'(bus.lcd_rs), 8'(prev_rs));
        end
        if (bus.ready === 1'b0) busy_cnt++;
        if (bus.lcd_e === 1'b1 && prev_e !== 1'b1) pulse_cnt++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.overrun === 1'b1) ov_cnt++;
        prev_e  = bus.lcd_e;
        prev_db = bus.lcd_db;
        prev_rs = bus.lcd_rs;
    endtask

    task automatic clear_counts();
        busy_cnt  = 0;
        pulse_cnt = 0;
        done_cnt  = 0;
        ov_cnt    = 0;
    endtask

    // One start pulse followed by idle cycles with junk on the data inputs
    task automatic run_write(input logic [7:0] d, input logic r, input logic lw,
                             input logic sn, input int n);
        clear_counts();
        apply_stimulus(1'b1, d, r, lw, sn);
        for (int i = 1; i < n; i++)
            apply_stimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        reset_exp = '{ready: 1'b1, done: 1'b0, e: 1'b0, rs: 1'b0, db: 4'h0};
        cur_exp    = reset_exp;
        exp_ov     = 1'b0;
        writes_cnt = 0;
        prev_e     = 1'b0;
        prev_db    = 4'h0;
        prev_rs    = 1'b0;
        clear_counts();
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.data_in       = 8'h00;
        bus.rs_in         = 1'b0;
        bus.long_wait     = 1'b0;
        bus.single_nibble = 1'b0;
        #3;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] two-nibble data write 0x4A");
        run_write(8'h4A, 1'b1, 1'b0, 1'b0, 25);
        check_count("t1_busy",   busy_cnt,  19);
        check_count("t1_pulses", pulse_cnt, 2);
        check_count("t1_done",   done_cnt,  1);

        $display("[TB] long command 0x01");
        run_write(8'h01, 1'b0, 1'b1, 1'b0, 30);
        check_count("t2_busy",   busy_cnt,  23);
        check_count("t2_pulses", pulse_cnt, 2);
        check_count("t2_done",   done_cnt,  1);

        $display("[TB] single nibble 0x30");
        run_write(8'h30, 1'b0, 1'b0, 1'b1, 15);
        check_count("t3_busy",   busy_cnt,  10);
        check_count("t3_pulses", pulse_cnt, 1);
        check_count("t3_done",   done_cnt,  1);

        $display("[TB] held start, data changed mid-write");
        clear_counts();
        for (int i = 1; i <= 70; i++)
            apply_stimulus(i <= 60, (i < 5) ? 8'h4A : 8'hFF, 1'b0, 1'b0, 1'b0);
        check_count("t4_done",    done_cnt,  3);
        check_count("t4_overrun", ov_cnt,    57);
        check_count("t4_busy",    busy_cnt,  57);

        $display("[TB] reset during lower-nibble pulse");
        clear_counts();
        apply_stimulus(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_output("t5_pulse_lo_e",  8'(bus.lcd_e),  8'h01);
        check_output("t5_pulse_lo_db", 8'(bus.lcd_db), 8'h0C);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("t5_async");
        exp_q.delete();
        cur_exp = reset_exp;
        prev_e  = 1'b0;
        prev_db = 4'h0;
        prev_rs = 1'b0;
        @(negedge clk);
        check_reset_values("t5_held");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_count("t5_no_done", done_cnt, 0);
        run_write(8'h5C, 1'b1, 1'b0, 1'b0, 25);
        check_count("t5_after_busy", busy_cnt, 19);
        check_count("t5_after_done", done_cnt, 1);

        $display("[TB] randomized traffic");
        clear_counts();
        writes_cnt = 0;
        for (int i = 0; i < 500; i++)
            apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_count("t6_done_vs_accepts", done_cnt, writes_cnt);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Parametrised LCD write-timing engine for HD44780-style character LCDs in 4-bit bus mode.
- Accepts one byte (command or data) per start handshake and drives lcd_e, lcd_rs and lcd_db with programmable setup, pulse, inter-nibble gap and post-write wait.
- Supports a single-nibble mode for the power-on init sequence and a long post-write wait for clear and home commands.
- Sits between the character/command controller and the LCD pins.

Parameters:
- E_SETUP_CYC, 2, cycles lcd_db and lcd_rs are stable before lcd_e rises (minimum 1).
- E_PULSE_CYC, 12, cycles lcd_e is held high per nibble (minimum 1).
- GAP_CYC, 50, cycles between the upper-nibble lcd_e fall and the start of lower-nibble setup (minimum 1).
- SHORT_WAIT_CYC, 2000, post-write wait for normal commands and data (minimum 1).
- LONG_WAIT_CYC, 82000, post-write wait when long_wait is set (minimum 1).
- CNT_W, 17, counter width; must hold max(parameter) - 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  write request; accepted only when ready=1
- data_in  in  8  byte to write; sampled at accept
- rs_in  in  1  0 = command, 1 = data; sampled at accept
- long_wait  in  1  selects LONG_WAIT_CYC; sampled at accept
- single_nibble  in  1  send data_in[7:4] only; sampled at accept
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when a write completes
- overrun  out  1  one-cycle pulse when start is asserted while busy
- lcd_e  out  1  LCD enable
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied to 0
- lcd_db  out  4  LCD data nibble (DB7..DB4)

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, counter = 0.
  - ready = 1, done = 0, overrun = 0, lcd_e = 0, lcd_rs = 0, lcd_db = 0.
  - All latched inputs = 0.
- Reset mid-operation: lcd_e falls immediately and the write is abandoned. No done pulse is generated.
- States:
  - IDLE
  - SETUP_HI
  - PULSE_HI
  - GAP
  - SETUP_LO
  - PULSE_LO
  - WAIT
- Accept: in IDLE with start=1 at a clock edge, latch data_in, rs_in, long_wait and single_nibble, clear the counter, and enter SETUP_HI. ready falls in the same edge.
- Each non-IDLE state lasts exactly its parameter count N cycles:
  - The counter is cleared on state entry.
  - The state exits when counter == N-1.
- Durations per state:
  - SETUP_HI: E_SETUP_CYC
  - PULSE_HI: E_PULSE_CYC
  - GAP: GAP_CYC
  - SETUP_LO: E_SETUP_CYC
  - PULSE_LO: E_PULSE_CYC
  - WAIT: SHORT_WAIT_CYC, or LONG_WAIT_CYC if long_wait was latched
- Transitions:
  - SETUP_HI -> PULSE_HI.
  - PULSE_HI -> GAP, or -> WAIT if single_nibble was latched.
  - GAP -> SETUP_LO -> PULSE_LO -> WAIT -> IDLE.
- Outputs (all registered):
  - lcd_e = 1 only in PULSE_HI and PULSE_LO.
  - lcd_db = latched[7:4] in SETUP_HI, PULSE_HI and GAP.
  - lcd_db = latched[3:0] in SETUP_LO and PULSE_LO.
  - lcd_db holds its last value in WAIT.
  - lcd_rs = latched rs from SETUP_HI through WAIT.
  - lcd_db and lcd_rs never change in a cycle where lcd_e is 1, or in the cycle lcd_e falls.
- Busy window:
  - Two-nibble write: ready is low for exactly 2*E_SETUP_CYC + 2*E_PULSE_CYC + GAP_CYC + wait cycles.
  - Single-nibble write: ready is low for exactly E_SETUP_CYC + E_PULSE_CYC + wait cycles.
- done is asserted on the edge WAIT -> IDLE, coincident with ready rising.
- Back-to-back writes: start may be held high. A new write is accepted in the first IDLE cycle, so there is no extra idle cycle after done.
- overrun: pulses for each cycle start=1 while ready=0. Such requests are dropped; there is no queueing and no effect on the current write.
- Input changes after accept have no effect until the next accept.

Test Plan:
Bench overrides: E_SETUP_CYC=2, E_PULSE_CYC=3, GAP_CYC=4, SHORT_WAIT_CYC=5, LONG_WAIT_CYC=9.
1. Two-nibble write: start with data_in=0x4A, rs_in=1 -> lcd_db=0x4 for 2 cycles, then lcd_e high for 3 cycles, then 4 gap cycles; lcd_db=0xA for 2 cycles, then lcd_e high for 3 cycles, then 5 wait cycles. lcd_rs=1 throughout, ready low for 19 cycles, one done pulse.
2. Long command: data_in=0x01, rs_in=0, long_wait=1 -> ready low for 23 cycles, lcd_rs=0, exactly two lcd_e pulses.
3. Single nibble: data_in=0x30, single_nibble=1 -> exactly one lcd_e pulse with lcd_db=0x3, ready low for 10 cycles.
4. Held start and mid-write change: start held for 3 writes with data_in changed to 0xFF mid-write -> writes back-to-back with no idle gap, the first write sends its original byte, overrun pulses every busy cycle, 3 done pulses.
5. Reset in PULSE_LO: assert rst -> lcd_e=0, lcd_db=0, ready=1 immediately, no done pulse. The next write completes normally.
6. Protocol check across randomized back-to-back writes with random data, rs_in, long_wait and single_nibble: lcd_db and lcd_rs never change while lcd_e=1 or in the cycle lcd_e falls, and lcd_rw is always 0.
